// File: rtl/dust_pkg.sv
// ---------------------------------------------------------------------------
// dust_pkg
// Shared types and default timing constants for the dust-mote reader-side
// pulse encoder.
//   dust_state_e     : encoder FSM states
//   DEF_*            : default parameter values (gap lengths in clock cycles)
//   WAKE_PULSES      : number of wake pulses that open every frame
// ---------------------------------------------------------------------------
package dust_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        GAP,
        BIT,
        TERM,
        DONE,
        SCAN
    } dust_state_e;

    localparam int DEF_AMP_W      = 4;
    localparam int DEF_SEP_LOW    = 1;
    localparam int DEF_SHORT_LOW  = 3;
    localparam int DEF_LONG_LOW   = 7;
    localparam int DEF_RX_TIMEOUT = 10;
    localparam int WAKE_PULSES    = 3;

endpackage

// File: rtl/dust_pulse_encoder_if.sv
// ---------------------------------------------------------------------------
// dust_pulse_encoder_if
// Request/status bundle between a frame requester and the pulse encoder.
//   start    : frame request
//   amp      : amplitude word, latched with an accepted start
//   scan     : scan-pulse request
//   busy     : encoder emitting, requests ignored
//   armed    : a frame has completed, scans are allowed
//   done     : one-cycle pulse at frame end
//   DATA_OUT : registered single-wire pulse line to the receiver
// Modports: master = requester side, slave = encoder side.
// ---------------------------------------------------------------------------
interface dust_pulse_encoder_if
    import dust_pkg::*;
#(
    parameter int AMP_W = DEF_AMP_W
);
    logic             start;
    logic [AMP_W-1:0] amp;
    logic             scan;
    logic             busy;
    logic             armed;
    logic             done;
    logic             DATA_OUT;

    modport master (
        output start, amp, scan,
        input  busy, armed, done, DATA_OUT
    );

    modport slave (
        input  start, amp, scan,
        output busy, armed, done, DATA_OUT
    );
endinterface

// File: rtl/dust_gap_timer.sv
// ---------------------------------------------------------------------------
// dust_gap_timer
// Loadable down-counter used to time every low gap on the pulse line.
// The counter stops at zero; zero is flagged combinationally from the count.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load (gap length minus one)
//   zero     : count has reached zero
// ---------------------------------------------------------------------------
module dust_gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q;

    assign zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (!zero) begin
            cnt_q <= cnt_q - W'(1);
        end
    end
endmodule

// File: rtl/dust_pulse_encoder.sv
// ---------------------------------------------------------------------------
// dust_pulse_encoder
// Reader-side pulse-pattern generator for the dust-mote receiver DATA_IN.
// A frame is: 3 wake pulses, AMP_W bits (MSB first) encoded by the two
// intra-bit gaps, and a terminate pulse. After a frame, scan pulses may be
// requested. All outputs are flops.
//   CLK_IN : clock
//   rst    : asynchronous active-low reset
//   bus    : dust_pulse_encoder_if slave (start/amp/scan in,
//            busy/armed/done/DATA_OUT out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start (or scan when armed)
// WAKE  | wake pulses with SEP_LOW gaps, pulse index 0..2
// GAP   | SEP_LOW low before each bit and before the terminate pulse
// BIT   | pulse, gap A, pulse, gap B, pulse; pulse index 0..2
// TERM  | terminate pulse
// DONE  | one cycle, done=1, armed=1; requests accepted as in IDLE
// SCAN  | one scan pulse, then SEP_LOW low
// ---------------------------------------------------------------------------
module dust_pulse_encoder
    import dust_pkg::*;
#(
    parameter int AMP_W      = DEF_AMP_W,
    parameter int SEP_LOW    = DEF_SEP_LOW,
    parameter int SHORT_LOW  = DEF_SHORT_LOW,
    parameter int LONG_LOW   = DEF_LONG_LOW,
    parameter int RX_TIMEOUT = DEF_RX_TIMEOUT
) (
    input  logic                 CLK_IN,
    input  logic                 rst,
    dust_pulse_encoder_if.slave  bus
);
    // The gap timer holds length-1, so SEP_LOW must be at least 1 as well.
    if (!(SEP_LOW >= 1 && SEP_LOW < SHORT_LOW && SHORT_LOW < LONG_LOW &&
          LONG_LOW < RX_TIMEOUT)) begin : g_param_check
        $error("dust_pulse_encoder: need 1 <= SEP_LOW < SHORT_LOW < LONG_LOW < RX_TIMEOUT");
    end

    localparam int TW  = $clog2(RX_TIMEOUT);
    localparam int BCW = (AMP_W > 1) ? $clog2(AMP_W) : 1;

    localparam logic [TW-1:0] SEP_V   = TW'(SEP_LOW - 1);
    localparam logic [TW-1:0] SHORT_V = TW'(SHORT_LOW - 1);
    localparam logic [TW-1:0] LONG_V  = TW'(LONG_LOW - 1);

    dust_state_e      state_q, state_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             armed_q, armed_d;
    logic [1:0]       pidx_q, pidx_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [AMP_W-1:0] sh_q, sh_d;
    logic             last_q, last_d;   // all bits sent, next GAP leads to TERM

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;
    logic             cur_bit;

    assign cur_bit = sh_q[AMP_W-1];

    dust_gap_timer #(
        .W (TW)
    ) u_gap_timer (
        .clk      (CLK_IN),
        .rst_n    (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK_IN or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
            pidx_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            armed_q <= armed_d;
            pidx_q  <= pidx_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
        end
    end

    // data_q is the pulse line itself: inside WAKE/BIT/SCAN a high data_q
    // marks the pulse cycle, where the following gap is loaded.
    always_comb begin
        state_d  = state_q;
        data_d   = 1'b0;
        armed_d  = armed_q;
        pidx_d   = pidx_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        last_d   = last_q;
        tmr_load = 1'b0;
        tmr_val  = SEP_V;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = WAKE;
                    data_d  = 1'b1;
                    armed_d = 1'b0;
                    pidx_d  = '0;
                    bcnt_d  = BCW'(AMP_W - 1);
                    sh_d    = bus.amp;
                    last_d  = 1'b0;
                end else if (bus.scan && armed_q) begin
                    state_d = SCAN;
                    data_d  = 1'b1;
                end
            end
            WAKE: begin
                if (data_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = SEP_V;
                    if (pidx_q == 2'(WAKE_PULSES - 1)) begin
                        state_d = GAP;
                    end else begin
                        pidx_d = pidx_q + 2'd1;
                    end
                end else if (tmr_zero) begin
                    data_d = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = last_q ? TERM : BIT;
                    data_d  = 1'b1;
                    pidx_d  = '0;
                end
            end
            BIT: begin
                if (data_q) begin
                    tmr_load = 1'b1;
                    case (pidx_q)
                        2'd0: begin
                            tmr_val = cur_bit ? LONG_V : SHORT_V;
                            pidx_d  = 2'd1;
                        end
                        2'd1: begin
                            tmr_val = cur_bit ? SHORT_V : LONG_V;
                            pidx_d  = 2'd2;
                        end
                        default: begin
                            tmr_val = SEP_V;
                            state_d = GAP;
                            sh_d    = sh_q << 1;
                            if (bcnt_q == '0) begin
                                last_d = 1'b1;
                            end else begin
                                bcnt_d = bcnt_q - BCW'(1);
                            end
                        end
                    endcase
                end else if (tmr_zero) begin
                    data_d = 1'b1;
                end
            end
            TERM: begin
                state_d = DONE;
                armed_d = 1'b1;
            end
            SCAN: begin
                if (data_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = SEP_V;
                end else if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they never glitch.
    assign busy_d = (state_d != IDLE) && (state_d != DONE);
    assign done_d = (state_d == DONE);

    assign bus.DATA_OUT = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.armed    = armed_q;
endmodule

// File: tb/tb_dust_pulse_encoder.sv
module tb_dust_pulse_encoder;
    localparam int AMP_W = 4;
    localparam int SEP   = 1;
    localparam int SHORT = 3;
    localparam int LONG  = 7;
    localparam int RXTO  = 10;
    // Cycles from first wake pulse through terminate pulse; done follows.
    localparam int FL = 3 + 2*SEP + AMP_W*(SEP + 3 + SHORT + LONG) + SEP + 1;

    logic CLK_IN = 1'b0;
    logic rst;

    dust_pulse_encoder_if #(.AMP_W(AMP_W)) bus();

    dust_pulse_encoder #(
        .AMP_W      (AMP_W),
        .SEP_LOW    (SEP),
        .SHORT_LOW  (SHORT),
        .LONG_LOW   (LONG),
        .RX_TIMEOUT (RXTO)
    ) dut (
        .CLK_IN (CLK_IN),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_assert = 0;
    int n_fail   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: pulse positions derived directly from the frame rules.
    function automatic logic [127:0] model_pattern(input logic [AMP_W-1:0] a);
        logic [127:0] p;
        int t;
        int ga;
        int gb;
        p = '0;
        t = 0;
        for (int w = 0; w < 3; w++) begin
            p[t] = 1'b1;
            if (w < 2) t += SEP + 1;
        end
        for (int i = AMP_W-1; i >= 0; i--) begin
            ga = a[i] ? LONG : SHORT;
            gb = a[i] ? SHORT : LONG;
            t += SEP + 1;  p[t] = 1'b1;
            t += ga + 1;   p[t] = 1'b1;
            t += gb + 1;   p[t] = 1'b1;
        end
        t += SEP + 1;
        p[t] = 1'b1;
        return p;
    endfunction

    // Receiver-style decoder: bit is 1 when the first gap is the longer one.
    task automatic decode(input logic [127:0] p, output logic [AMP_W-1:0] a, output int maxlow);
        int times[$];
        int run;
        int d1;
        int d2;
        run    = 0;
        maxlow = 0;
        a      = '0;
        for (int t = 0; t < FL; t++) begin
            if (p[t]) begin
                times.push_back(t);
                run = 0;
            end else begin
                run++;
                if (run > maxlow) maxlow = run;
            end
        end
        for (int i = 0; i < AMP_W; i++) begin
            if (times.size() >= 6 + 3*i) begin
                d1 = times[4 + 3*i] - times[3 + 3*i];
                d2 = times[5 + 3*i] - times[4 + 3*i];
                a  = {a[AMP_W-2:0], (d1 > d2)};
            end
        end
    endtask

    task automatic capture_frame(input logic [AMP_W-1:0] a, input bit with_scan, input int inj,
                                 output logic [127:0] pat, output int done_at,
                                 output logic busy0, output logic armed0,
                                 output logic busy_done, output logic armed_done);
        @(negedge CLK_IN);
        bus.start = 1'b1;
        bus.amp   = a;
        bus.scan  = with_scan;
        pat        = '0;
        done_at    = -1;
        busy0      = 1'bx;
        armed0     = 1'bx;
        busy_done  = 1'bx;
        armed_done = 1'bx;
        for (int t = 0; t < FL + 4; t++) begin
            @(negedge CLK_IN);
            if (t == 0) begin
                bus.start = 1'b0;
                bus.scan  = 1'b0;
                bus.amp   = ~a;
                busy0     = bus.busy;
                armed0    = bus.armed;
            end
            pat[t] = bus.DATA_OUT;
            if (bus.done === 1'b1 && done_at < 0) begin
                done_at    = t;
                busy_done  = bus.busy;
                armed_done = bus.armed;
            end
            if (t == inj) bus.start = 1'b1;
            if (t == inj + 1) bus.start = 1'b0;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [AMP_W-1:0] a, input bit with_scan,
                                 input int inj, output logic [127:0] pat, output int maxlow);
        int done_at;
        logic b0, a0, bd, ad;
        logic [AMP_W-1:0] dec;
        capture_frame(a, with_scan, inj, pat, done_at, b0, a0, bd, ad);
        check({tag, " pattern"},    pat, model_pattern(a));
        check({tag, " done_at"},    128'(done_at), 128'(FL));
        check({tag, " busy_first"}, 128'(b0), 128'(1));
        check({tag, " armed_first"},128'(a0), 128'(0));
        check({tag, " busy_done"},  128'(bd), 128'(0));
        check({tag, " armed_done"}, 128'(ad), 128'(1));
        decode(pat, dec, maxlow);
        check({tag, " decoded_amp"},128'(dec), 128'(a));
    endtask

    initial begin
        logic [127:0] pat;
        logic [127:0] lit;
        int maxlow;
        int maxlow_all;
        int order[16];
        int j;
        int tmp;
        int inj;
        logic acc;
        logic [1:0] s1, s2;
        logic [2:0] s3;
        int pos_1011[16] = '{0, 2, 4, 6, 14, 18, 20, 24, 32, 34, 42, 46, 48, 56, 60, 62};

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.scan  = 1'b0;
        bus.amp   = '0;
        repeat (3) @(negedge CLK_IN);
        check("reset_outputs", 128'({bus.DATA_OUT, bus.busy, bus.armed, bus.done}), 128'(0));
        rst = 1'b1;
        @(negedge CLK_IN);

        // Scan before any frame must be ignored.
        bus.scan = 1'b1;
        @(negedge CLK_IN);
        bus.scan = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc = acc | bus.DATA_OUT | bus.busy;
            @(negedge CLK_IN);
        end
        check("scan_unarmed", 128'(acc), 128'(0));

        // Directed frame with literal pulse positions.
        run_and_check("f1011", 4'b1011, 1'b0, -1, pat, maxlow);
        lit = '0;
        for (int i = 0; i < 16; i++) lit[pos_1011[i]] = 1'b1;
        check("f1011 literal_positions", pat, lit);

        // Three scans spaced three cycles apart.
        for (int k = 0; k < 3; k++) begin
            bus.scan = 1'b1;
            @(negedge CLK_IN);
            bus.scan = 1'b0;
            s1 = {bus.DATA_OUT, bus.busy};
            @(negedge CLK_IN);
            s2 = {bus.DATA_OUT, bus.busy};
            @(negedge CLK_IN);
            s3 = {bus.DATA_OUT, bus.busy, bus.armed};
            check("scan_pulse", 128'(s1), 128'(2'b11));
            check("scan_gap",   128'(s2), 128'(2'b01));
            check("scan_after", 128'(s3), 128'(3'b001));
        end

        // start pulsed while busy is ignored.
        run_and_check("busy_start", 4'b0110, 1'b0, 10, pat, maxlow);

        // start and scan together while armed: start wins.
        run_and_check("start_scan", 4'b1100, 1'b1, -1, pat, maxlow);

        // Asynchronous reset mid-frame.
        @(negedge CLK_IN);
        bus.start = 1'b1;
        bus.amp   = 4'($urandom_range(0, 15));
        @(negedge CLK_IN);
        bus.start = 1'b0;
        repeat (30) @(negedge CLK_IN);
        check("busy_before_reset", 128'(bus.busy), 128'(1));
        #2 rst = 1'b0;
        #1 check("async_reset", 128'({bus.DATA_OUT, bus.busy, bus.armed}), 128'(0));
        @(negedge CLK_IN);
        check("held_reset", 128'({bus.DATA_OUT, bus.busy, bus.armed, bus.done}), 128'(0));
        rst = 1'b1;
        @(negedge CLK_IN);
        run_and_check("after_reset", 4'b0000, 1'b0, -1, pat, maxlow);

        // Sweep all amplitudes in random order with random idle gaps.
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        maxlow_all = 0;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK_IN);
            inj = (i % 2 == 1) ? int'($urandom_range(1, FL - 3)) : -1;
            run_and_check($sformatf("sweep_%0d", order[i]), 4'(order[i]), 1'b0, inj, pat, maxlow);
            if (maxlow > maxlow_all) maxlow_all = maxlow;
        end
        check("max_low_run", 128'(maxlow_all), 128'(LONG));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dust_pulse_encoder.md
# dust_pulse_encoder

- Reader-side pulse-pattern generator that drives the single-wire `DATA_IN` of the dust-mote receiver FSM.
- On a start request it emits a full command frame: wake pulses, an amplitude word encoded by inter-pulse spacing, and a terminate pulse.
- After a frame it issues scan pulses on request.
- It sits directly upstream of the receiver; `DATA_OUT` connects to the receiver's `DATA_IN`.

## Interface
Parameters:
- `AMP_W`, 4, amplitude word width; sent MSB first.
- `SEP_LOW`, 1, low cycles between adjacent pulses (wake, bit-to-bit, terminate).
- `SHORT_LOW`, 3, short intra-bit low gap.
- `LONG_LOW`, 7, long intra-bit low gap.
- `RX_TIMEOUT`, 10, receiver timeout in cycles. Elaboration error unless `SEP_LOW < SHORT_LOW < LONG_LOW < RX_TIMEOUT`.

Ports:
- `CLK_IN` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: frame request, sampled at posedge.
- `amp` in `AMP_W`: amplitude, latched with the accepted `start`.
- `scan` in 1: scan-pulse request.
- `busy` out 1: encoder emitting; requests ignored.
- `armed` out 1: frame completed, scans allowed.
- `done` out 1: one-cycle pulse at frame end.
- `DATA_OUT` out 1: registered pulse line to the receiver.

## Operation
- Reset: all outputs 0, state IDLE. Reset asserted mid-frame forces `DATA_OUT` low immediately and discards the frame.
- States:
  - IDLE: waits for a request.
  - WAKE: 3 pulses, each separated by `SEP_LOW`.
  - GAP: `SEP_LOW`, inserted before each bit and before the terminate pulse.
  - BIT: pulse, gap A, pulse, gap B, pulse.
    - bit 1: A=`LONG_LOW`, B=`SHORT_LOW`.
    - bit 0: A=`SHORT_LOW`, B=`LONG_LOW`.
  - TERM: 1 pulse.
  - DONE: 1 cycle.
  - SCAN: 1 pulse, then `SEP_LOW` low.
- Each pulse is exactly 1 cycle high.
- Bits are sent `amp[AMP_W-1]` down to `amp[0]`, using a shift register loaded on accept.
- In IDLE, an accepted `start` clears `armed` and goes to WAKE.
- An accepted `scan` requires `armed=1` and goes to SCAN.
- `start` and `scan` asserted in the same cycle: `start` wins.
- `scan` with `armed=0` is ignored.
- DONE sets `armed`.
- `armed` stays set across scans until the next accepted `start` or reset.

## Timing
- `start` sampled at edge k: `busy` and the first `DATA_OUT` high both occur in cycle k+1.
- Frame, defaults (`AMP_W`=4): 63 cycles from the first wake pulse through the terminate pulse.
  - wake 5, then 4×(`SEP_LOW` + 13), then `SEP_LOW` + 1.
  - General: 3+2·`SEP_LOW` + `AMP_W`·(`SEP_LOW`+3+`SHORT_LOW`+`LONG_LOW`) + `SEP_LOW`+1.
- Cycle after the terminate pulse: `done`=1, `busy`=0, `armed`=1. A `start` sampled in that cycle is accepted.
- Scan: `scan` at edge k gives `DATA_OUT` high in cycle k+1 and `busy` high for cycles k+1..k+1+`SEP_LOW`.
- No low run inside a frame exceeds `LONG_LOW`, so the receiver never times out mid-frame.
- `busy` never glitches; `DATA_OUT` is a flop output only.

## Structure
- Shared package `dust_pkg`:
  - state enum (IDLE, WAKE, GAP, BIT, TERM, DONE, SCAN)
  - default gap constants
  - wake pulse count (3)
- Sub-module `dust_gap_timer`: loadable down-counter with a `zero` flag, reused for every low gap.
- Top level holds the FSM, the pulse-index counter (0..2), the bit counter (`AMP_W`-1..0) and the amp shift register.

## Test plan
- Reset then `start`, `amp`=4'b1011: `DATA_OUT` pulse positions relative to the first pulse (cycle 0).
  - Wake: 0,2,4.
  - Bit 1: 6,14,18.
  - Bit 0: 20,24,32.
  - Bit 1: 34,42,46.
  - Bit 1: 48,56,60.
  - Terminate: 62.
  - `done` at 63.
  - Connected receiver reaches state 7 and, after scans, decodes amplitude 1011.
- After the frame, 3 `scan` requests spaced ≥2 cycles: 3 single-cycle pulses, receiver steps 7→8→9→8, `armed` stays 1.
- `start` pulsed while `busy`, and `scan` before any frame: no effect on `DATA_OUT` and no `busy`.
- `start` and `scan` in the same idle cycle with `armed`=1: a frame is sent, `armed` drops to 0.
- `rst` low at cycle 30 of a frame: `DATA_OUT`, `busy`, `armed` = 0 asynchronously. A new `start` with `amp`=4'b0000 yields a full, correct 63-cycle frame.
- Sweep all 16 `amp` values: the pulse-spacing decoder in the bench recovers each value, and the maximum observed low run is `LONG_LOW`=7.
